// File: rtl/usb_ep_pkg.sv
// Shared types and sizes for the USB endpoint bridges.
package usb_ep_pkg;

    localparam int BYTE_W    = 8;
    localparam int BUF_DEPTH = 2;
    localparam int BUF_CNT_W = 2;

    localparam logic [BUF_CNT_W-1:0] BUF_FULL = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/usb_ep_buf2.sv
// Two-entry synchronous byte FIFO with occupancy count; head is visible without a pop.
module usb_ep_buf2
    import usb_ep_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [BYTE_W-1:0]    din_i,
    output logic [BYTE_W-1:0]    dout_o,
    output logic [BUF_CNT_W-1:0] count_o
);

    logic [BYTE_W-1:0]    mem_q [BUF_DEPTH];
    logic [BYTE_W-1:0]    mem_d [BUF_DEPTH];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [BUF_CNT_W-1:0] count_q, count_d;
    logic                 push_ok_s;
    logic                 pop_ok_s;

    // Requests that would overflow or underflow are dropped here as a backstop.
    always_comb begin
        push_ok_s = push_i && (count_q != BUF_FULL);
        pop_ok_s  = pop_i && (count_q != 2'd0);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/usb_ep_bridge.sv
// Bridges usb1_top EP2 (OUT) / EP1 (IN) FIFOs to valid/ready byte streams,
// with an internal EP2->EP1 loopback and byte counters.
module usb_ep_bridge
    import usb_ep_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             loop_i,
    input  logic [7:0]       ep2_dout_i,
    input  logic             ep2_empty_i,
    output logic             ep2_re_o,
    output logic [7:0]       ep1_din_o,
    output logic             ep1_we_o,
    input  logic             ep1_full_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    input  logic [7:0]       tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic [CNT_W-1:0] rx_count_o,
    output logic [CNT_W-1:0] tx_count_o,
    output logic [7:0]       led_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    rd_state_e            state_q, state_d;
    logic                 ep2_re_q, ep2_re_d;
    logic [CNT_W-1:0]     rx_count_q, rx_count_d;
    logic [7:0]           led_q, led_d;
    logic [7:0]           ep1_din_q, ep1_din_d;
    logic                 ep1_we_q, ep1_we_d;
    logic [CNT_W-1:0]     tx_count_q, tx_count_d;
    logic                 wr_open_q, wr_open_d;
    logic                 cap_s;
    logic                 pop_s;
    logic                 tx_acc_s;
    logic                 loop_pop_s;
    logic [BYTE_W-1:0]    buf_head_s;
    logic [BUF_CNT_W-1:0] buf_count_s;

    usb_ep_buf2 u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cap_s),
        .pop_i   (pop_s),
        .din_i   (ep2_dout_i),
        .dout_o  (buf_head_s),
        .count_o (buf_count_s)
    );

    // Only one read is ever in flight, so free space checked in IDLE still exists at CAP.
    always_comb begin
        state_d  = state_q;
        ep2_re_d = 1'b0;
        cap_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ep2_empty_i && (buf_count_s < BUF_FULL)) begin
                    state_d  = RD;
                    ep2_re_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RD:      state_d = CAP;
            CAP: begin
                cap_s   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_valid_o = (buf_count_s != 2'd0) && !loop_i;
    assign rx_data_o  = buf_head_s;
    // wr_open_q stays low through the strobe cycle and one more to ride out EP1 full-flag lag.
    assign tx_ready_o = !loop_i && !ep1_full_i && wr_open_q;
    assign tx_acc_s   = tx_valid_i && tx_ready_o;
    assign loop_pop_s = loop_i && (buf_count_s != 2'd0) && !ep1_full_i && wr_open_q;
    assign pop_s      = (rx_valid_o && rx_ready_i) || loop_pop_s;

    always_comb begin
        ep1_din_d  = ep1_din_q;
        ep1_we_d   = 1'b0;
        tx_count_d = tx_count_q;
        rx_count_d = rx_count_q;
        led_d      = led_q;
        wr_open_d  = !(tx_acc_s || loop_pop_s) && !ep1_we_q;
        if (tx_acc_s) begin
            ep1_din_d  = tx_data_i;
            ep1_we_d   = 1'b1;
            tx_count_d = tx_count_q + CNT_ONE;
        end else if (loop_pop_s) begin
            ep1_din_d  = buf_head_s;
            ep1_we_d   = 1'b1;
            tx_count_d = tx_count_q + CNT_ONE;
        end else begin
            ep1_din_d = ep1_din_q;
        end
        if (cap_s) begin
            rx_count_d = rx_count_q + CNT_ONE;
            led_d      = ep2_dout_i;
        end else begin
            led_d = led_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            ep2_re_q   <= 1'b0;
            rx_count_q <= '0;
            led_q      <= 8'h00;
            ep1_din_q  <= 8'h00;
            ep1_we_q   <= 1'b0;
            tx_count_q <= '0;
            wr_open_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ep2_re_q   <= ep2_re_d;
            rx_count_q <= rx_count_d;
            led_q      <= led_d;
            ep1_din_q  <= ep1_din_d;
            ep1_we_q   <= ep1_we_d;
            tx_count_q <= tx_count_d;
            wr_open_q  <= wr_open_d;
        end
    end

    assign ep2_re_o   = ep2_re_q;
    assign ep1_din_o  = ep1_din_q;
    assign ep1_we_o   = ep1_we_q;
    assign rx_count_o = rx_count_q;
    assign tx_count_o = tx_count_q;
    assign led_o      = led_q;

endmodule

// File: tb/tb_usb_ep_bridge.sv
// Scoreboard bench for usb_ep_bridge: EP2 FIFO model, negedge monitors, per-feature tasks.
module tb_usb_ep_bridge;

    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             loop_i = 1'b0;
    logic [7:0]       ep2_dout_i = 8'h00;
    logic             ep2_empty_i;
    logic             ep2_re_o;
    logic [7:0]       ep1_din_o;
    logic             ep1_we_o;
    logic             ep1_full_i = 1'b0;
    logic [7:0]       rx_data_o;
    logic             rx_valid_o;
    logic             rx_ready_i = 1'b0;
    logic [7:0]       tx_data_i = 8'h00;
    logic             tx_valid_i = 1'b0;
    logic             tx_ready_o;
    logic [CNT_W-1:0] rx_count_o;
    logic [CNT_W-1:0] tx_count_o;
    logic [7:0]       led_o;

    usb_ep_bridge #(.CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .loop_i      (loop_i),
        .ep2_dout_i  (ep2_dout_i),
        .ep2_empty_i (ep2_empty_i),
        .ep2_re_o    (ep2_re_o),
        .ep1_din_o   (ep1_din_o),
        .ep1_we_o    (ep1_we_o),
        .ep1_full_i  (ep1_full_i),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .tx_data_i   (tx_data_i),
        .tx_valid_i  (tx_valid_i),
        .tx_ready_o  (tx_ready_o),
        .rx_count_o  (rx_count_o),
        .tx_count_o  (tx_count_o),
        .led_o       (led_o)
    );

    always #5 clk_i = ~clk_i;

    // EP2 OUT FIFO model: data appears the cycle after the read strobe.
    logic [7:0] ep2_mem [64];
    int         ep2_wp = 0;
    int         ep2_rp = 0;

    assign ep2_empty_i = (ep2_rp == ep2_wp);

    always @(posedge clk_i) begin
        if (ep2_re_o && (ep2_rp != ep2_wp)) begin
            ep2_dout_i <= ep2_mem[ep2_rp % 64];
            ep2_rp     <= ep2_rp + 1;
        end
    end

    // Monitors record DUT output events away from the active edge.
    logic [7:0] rx_obs [64];
    logic [7:0] ep1_obs [64];
    int         rx_obs_n = 0;
    int         ep1_obs_n = 0;
    int         re_pulses = 0;
    int         re_consec = 0;
    int         we_consec = 0;
    int         loop_leak = 0;
    logic       re_prev = 1'b0;
    logic       we_prev = 1'b0;

    always @(negedge clk_i) begin
        if (rx_valid_o && rx_ready_i) begin
            rx_obs[rx_obs_n % 64] <= rx_data_o;
            rx_obs_n              <= rx_obs_n + 1;
        end
        if (ep1_we_o) begin
            ep1_obs[ep1_obs_n % 64] <= ep1_din_o;
            ep1_obs_n               <= ep1_obs_n + 1;
        end
        if (ep2_re_o) re_pulses <= re_pulses + 1;
        if (ep2_re_o && re_prev) re_consec <= re_consec + 1;
        if (ep1_we_o && we_prev) we_consec <= we_consec + 1;
        if (loop_i && rx_valid_o) loop_leak <= loop_leak + 1;
        re_prev <= ep2_re_o;
        we_prev <= ep1_we_o;
    end

    logic [7:0] rx_exp [$];
    logic [7:0] ep1_exp [$];
    int         rx_rd = 0;
    int         ep1_rd = 0;
    int         exp_rx = 0;
    int         exp_tx = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic load_ep2(input logic [7:0] b);
        ep2_mem[ep2_wp % 64] = b;
        ep2_wp = ep2_wp + 1;
    endtask

    task automatic wait_rx(input int n, output bit ok);
        for (int i = 0; i < 300; i++) begin
            if (rx_obs_n >= n) break;
            tick(1);
        end
        ok = (rx_obs_n >= n);
    endtask

    task automatic wait_ep1(input int n, output bit ok);
        for (int i = 0; i < 300; i++) begin
            if (ep1_obs_n >= n) break;
            tick(1);
        end
        ok = (ep1_obs_n >= n);
    endtask

    task automatic send_tx(input logic [7:0] b, output bit ok);
        ok         = 1'b0;
        tx_data_i  = b;
        tx_valid_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (tx_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk_i);
        #1;
        tx_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b0;
        tick(2);
        n_checks++;
        if ({ep2_re_o, ep1_we_o, rx_valid_o, tx_ready_o} !== 4'b0000) begin
            $display("FAIL reset_strobes: got %b want 0000", {ep2_re_o, ep1_we_o, rx_valid_o, tx_ready_o});
        end else n_pass++;
        n_checks++;
        if ({rx_count_o, tx_count_o, led_o, ep1_din_o, rx_data_o} !== 32'h0) begin
            $display("FAIL reset_data: got %h want 0", {rx_count_o, tx_count_o, led_o, ep1_din_o, rx_data_o});
        end else n_pass++;
        rst_i  = 1'b1;
        exp_rx = 0;
        exp_tx = 0;
        tick(2);
    endtask

    task automatic test_rx_stream;
        bit ok;
        int base;
        base       = rx_obs_n;
        rx_ready_i = 1'b1;
        load_ep2(8'h11); rx_exp.push_back(8'h11);
        load_ep2(8'h22); rx_exp.push_back(8'h22);
        load_ep2(8'h33); rx_exp.push_back(8'h33);
        exp_rx += 3;
        wait_rx(base + 3, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL rx_stream_timeout: got %0d bytes want %0d", rx_obs_n - base, 3);
        else n_pass++;
        while (rx_exp.size() > 0 && rx_rd < rx_obs_n) begin
            logic [7:0] e;
            e = rx_exp.pop_front();
            n_checks++;
            if (rx_obs[rx_rd % 64] !== e) $display("FAIL rx_stream_data: got %h want %h", rx_obs[rx_rd % 64], e);
            else n_pass++;
            rx_rd++;
        end
        tick(3);
        n_checks++;
        if (rx_count_o !== CNT_W'(exp_rx)) $display("FAIL rx_count: got %0d want %0d", rx_count_o, exp_rx % 16);
        else n_pass++;
        n_checks++;
        if (led_o !== 8'h33) $display("FAIL led: got %h want 33", led_o);
        else n_pass++;
        n_checks++;
        if (re_consec !== 0) $display("FAIL re_consecutive: got %0d want 0", re_consec);
        else n_pass++;
    endtask

    task automatic test_rx_backpressure;
        bit ok;
        int re0;
        int base;
        rx_ready_i = 1'b0;
        re0        = re_pulses;
        base       = rx_obs_n;
        for (int i = 0; i < 4; i++) begin
            load_ep2(8'h44 + 8'(i * 17));
            rx_exp.push_back(8'h44 + 8'(i * 17));
        end
        exp_rx += 4;
        tick(30);
        n_checks++;
        if (re_pulses - re0 !== 2) $display("FAIL bp_read_count: got %0d want 2", re_pulses - re0);
        else n_pass++;
        n_checks++;
        if ({rx_valid_o, rx_data_o} !== {1'b1, 8'h44}) $display("FAIL bp_head: got %b/%h want 1/44", rx_valid_o, rx_data_o);
        else n_pass++;
        n_checks++;
        if (ep2_wp - ep2_rp !== 2) $display("FAIL bp_ep2_left: got %0d want 2", ep2_wp - ep2_rp);
        else n_pass++;
        rx_ready_i = 1'b1;
        wait_rx(base + 4, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL bp_timeout: got %0d bytes want 4", rx_obs_n - base);
        else n_pass++;
        while (rx_exp.size() > 0 && rx_rd < rx_obs_n) begin
            logic [7:0] e;
            e = rx_exp.pop_front();
            n_checks++;
            if (rx_obs[rx_rd % 64] !== e) $display("FAIL bp_data: got %h want %h", rx_obs[rx_rd % 64], e);
            else n_pass++;
            rx_rd++;
        end
        tick(3);
        n_checks++;
        if (rx_count_o !== CNT_W'(exp_rx)) $display("FAIL bp_rx_count: got %0d want %0d", rx_count_o, exp_rx % 16);
        else n_pass++;
    endtask

    task automatic test_tx;
        bit ok;
        int base;
        base = ep1_obs_n;
        send_tx(8'hA5, ok); ep1_exp.push_back(8'hA5);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL tx_accept_a5: got %b want 1", ok);
        else n_pass++;
        send_tx(8'h5A, ok); ep1_exp.push_back(8'h5A);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL tx_accept_5a: got %b want 1", ok);
        else n_pass++;
        exp_tx += 2;
        wait_ep1(base + 2, ok);
        tick(2);
        while (ep1_exp.size() > 0 && ep1_rd < ep1_obs_n) begin
            logic [7:0] e;
            e = ep1_exp.pop_front();
            n_checks++;
            if (ep1_obs[ep1_rd % 64] !== e) $display("FAIL tx_data: got %h want %h", ep1_obs[ep1_rd % 64], e);
            else n_pass++;
            ep1_rd++;
        end
        n_checks++;
        if (we_consec !== 0) $display("FAIL tx_spacing: got %0d back-to-back strobes want 0", we_consec);
        else n_pass++;
        n_checks++;
        if (tx_count_o !== CNT_W'(exp_tx)) $display("FAIL tx_count: got %0d want %0d", tx_count_o, exp_tx % 16);
        else n_pass++;
        ep1_full_i = 1'b1;
        tx_data_i  = 8'hEE;
        tx_valid_i = 1'b1;
        tick(6);
        n_checks++;
        if (tx_ready_o !== 1'b0) $display("FAIL full_ready: got %b want 0", tx_ready_o);
        else n_pass++;
        n_checks++;
        if (ep1_obs_n !== base + 2) $display("FAIL full_no_write: got %0d writes want %0d", ep1_obs_n - base, 2);
        else n_pass++;
        tx_valid_i = 1'b0;
        ep1_full_i = 1'b0;
        tick(2);
    endtask

    task automatic test_loop;
        bit ok;
        int base;
        base       = ep1_obs_n;
        rx_ready_i = 1'b1;
        loop_i     = 1'b1;
        tick(1);
        for (int i = 1; i <= 4; i++) begin
            load_ep2(8'(i));
            ep1_exp.push_back(8'(i));
        end
        exp_rx += 4;
        exp_tx += 4;
        wait_ep1(base + 4, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL loop_timeout: got %0d bytes want 4", ep1_obs_n - base);
        else n_pass++;
        tick(3);
        while (ep1_exp.size() > 0 && ep1_rd < ep1_obs_n) begin
            logic [7:0] e;
            e = ep1_exp.pop_front();
            n_checks++;
            if (ep1_obs[ep1_rd % 64] !== e) $display("FAIL loop_data: got %h want %h", ep1_obs[ep1_rd % 64], e);
            else n_pass++;
            ep1_rd++;
        end
        n_checks++;
        if (loop_leak !== 0) $display("FAIL loop_rx_valid: got %0d cycles high want 0", loop_leak);
        else n_pass++;
        n_checks++;
        if ({rx_count_o, tx_count_o} !== {CNT_W'(exp_rx), CNT_W'(exp_tx)}) begin
            $display("FAIL loop_counts: got %0d/%0d want %0d/%0d", rx_count_o, tx_count_o, exp_rx % 16, exp_tx % 16);
        end else n_pass++;
        loop_i = 1'b0;
        tick(2);
    endtask

    task automatic test_reset_mid_read;
        bit ok;
        bit seen;
        int base;
        rx_ready_i = 1'b0;
        load_ep2(8'h99);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (rx_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (seen !== 1'b1) $display("FAIL mid_buffered: got %b want 1", seen);
        else n_pass++;
        load_ep2(8'hAA);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (ep2_re_o) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (seen !== 1'b1) $display("FAIL mid_in_rd: got %b want 1", seen);
        else n_pass++;
        rst_i = 1'b0;
        #1;
        n_checks++;
        if ({ep2_re_o, ep1_we_o, rx_valid_o, tx_ready_o, rx_count_o, tx_count_o, led_o, ep1_din_o, rx_data_o} !== 36'h0) begin
            $display("FAIL mid_reset_outputs: got %h want 0",
                     {ep2_re_o, ep1_we_o, rx_valid_o, tx_ready_o, rx_count_o, tx_count_o, led_o, ep1_din_o, rx_data_o});
        end else n_pass++;
        tick(2);
        rst_i  = 1'b1;
        exp_rx = 0;
        exp_tx = 0;
        n_checks++;
        if (rx_valid_o !== 1'b0) $display("FAIL mid_buf_empty: got %b want 0", rx_valid_o);
        else n_pass++;
        base       = rx_obs_n;
        rx_ready_i = 1'b1;
        rx_exp.push_back(8'hAA);
        exp_rx += 1;
        wait_rx(base + 1, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL mid_restart_timeout: got %0d bytes want 1", rx_obs_n - base);
        else n_pass++;
        while (rx_exp.size() > 0 && rx_rd < rx_obs_n) begin
            logic [7:0] e;
            e = rx_exp.pop_front();
            n_checks++;
            if (rx_obs[rx_rd % 64] !== e) $display("FAIL mid_restart_data: got %h want %h", rx_obs[rx_rd % 64], e);
            else n_pass++;
            rx_rd++;
        end
        tick(2);
        n_checks++;
        if ({rx_count_o, led_o} !== {CNT_W'(exp_rx), 8'hAA}) $display("FAIL mid_restart_state: got %0d/%h want 1/aa", rx_count_o, led_o);
        else n_pass++;
    endtask

    task automatic test_counter_wrap;
        bit ok;
        bit all_ok;
        int base;
        base   = ep1_obs_n;
        all_ok = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send_tx(8'(i * 7 + 3), ok);
            ep1_exp.push_back(8'(i * 7 + 3));
            all_ok = all_ok & ok;
        end
        exp_tx += 17;
        n_checks++;
        if (all_ok !== 1'b1) $display("FAIL wrap_accept: got %b want 1", all_ok);
        else n_pass++;
        wait_ep1(base + 17, ok);
        tick(2);
        while (ep1_exp.size() > 0 && ep1_rd < ep1_obs_n) begin
            logic [7:0] e;
            e = ep1_exp.pop_front();
            n_checks++;
            if (ep1_obs[ep1_rd % 64] !== e) $display("FAIL wrap_data: got %h want %h", ep1_obs[ep1_rd % 64], e);
            else n_pass++;
            ep1_rd++;
        end
        n_checks++;
        if (ep1_exp.size() !== 0) $display("FAIL wrap_missing: got %0d outstanding want 0", ep1_exp.size());
        else n_pass++;
        n_checks++;
        if (tx_count_o !== 4'd1) $display("FAIL wrap_tx_count: got %0d want 1", tx_count_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rx_stream();
        test_rx_backpressure();
        test_tx();
        test_loop();
        test_reset_mid_read();
        test_counter_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
